// File: rtl/sample_source_pkg.sv
// Shared encodings and LFSR helpers for the sample_source generator.
package sample_source_pkg;

  typedef enum logic [1:0] {
    MODE_CONST  = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_NOISE  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Taps of x^8+x^6+x^5+x^4+1 expressed as register bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/nco_strobe.sv
// Phase accumulator whose carry-out marks one sample-rate strobe.
module nco_strobe #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [ACC_W-1:0] i_fcw,
  output logic             o_strobe
);

  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] r_acc;

  assign w_sum    = {1'b0, r_acc} + {1'b0, i_fcw};
  // A clear on the same edge suppresses the strobe so callers can give it priority.
  assign o_strobe = i_en & ~i_clr & w_sum[ACC_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/sample_source.sv
// Strobed signed 8-bit stimulus source (const/square/ramp/noise) with
// continuous or fixed-length burst runs.
module sample_source
  import sample_source_pkg::*;
#(
  parameter int ACC_W   = 16,
  parameter int SQ_HALF = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    abort,
  input  logic [1:0]              mode,
  input  logic signed [7:0]       amp,
  input  logic [ACC_W-1:0]        fcw,
  input  logic [CNT_W-1:0]        burst_len,
  output logic signed [7:0]       x_n,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int SQ_W = (SQ_HALF > 1) ? $clog2(SQ_HALF) : 1;
  localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQ_HALF - 1);

  function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
    return (v == 8'sh80) ? 8'sh7F : -v;
  endfunction

  state_e             r_state;
  state_e             w_next;
  mode_e              r_mode;
  logic signed [7:0]  r_amp;
  logic [CNT_W-1:0]   r_burst;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [7:0]         r_lfsr;
  logic signed [7:0]  r_ramp;
  logic               r_sq_pos;
  logic [SQ_W-1:0]    r_sq_cnt;
  logic signed [7:0]  w_sample;
  logic               w_start_run;
  logic               w_strobe;
  logic               w_fire;
  logic               w_last;

  assign w_start_run = (r_state == ST_IDLE) && start && !abort;
  assign w_fire      = (r_state == ST_RUN) && w_strobe;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign w_last      = (r_burst != '0) && (w_cnt_inc == r_burst);

  nco_strobe #(
    .ACC_W(ACC_W)
  ) u_nco (
    .clk     (clk),
    .resetn  (resetn),
    .i_clr   (w_start_run | abort),
    .i_en    (r_state == ST_RUN),
    .i_fcw   (fcw),
    .o_strobe(w_strobe)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start_run) w_next = ST_RUN;
      ST_RUN: begin
        if (abort) begin
          w_next = ST_IDLE;
        end else if (w_fire && w_last) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // busy and done mirror the registered state so they can never glitch.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next == ST_RUN);
      done    <= (w_next == ST_DONE);
    end
  end

  always_comb begin
    w_sample = r_amp;
    case (r_mode)
      MODE_SQUARE: w_sample = r_sq_pos ? r_amp : neg_sat(r_amp);
      MODE_RAMP:   w_sample = r_ramp;
      MODE_NOISE:  w_sample = r_lfsr;
      default:     w_sample = r_amp;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mode   <= MODE_CONST;
      r_amp    <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_lfsr   <= LFSR_SEED;
      r_ramp   <= 8'sh80;
      r_sq_pos <= 1'b1;
      r_sq_cnt <= '0;
      x_n      <= '0;
      x_valid  <= 1'b0;
    end else begin
      x_valid <= 1'b0;
      if (w_start_run) begin
        r_mode   <= mode_e'(mode);
        r_amp    <= amp;
        r_burst  <= burst_len;
        r_cnt    <= '0;
        r_lfsr   <= LFSR_SEED;
        r_ramp   <= 8'sh80;
        r_sq_pos <= 1'b1;
        r_sq_cnt <= '0;
      end else if (w_fire) begin
        x_n     <= w_sample;
        x_valid <= 1'b1;
        r_cnt   <= w_cnt_inc;
        r_lfsr  <= lfsr_step(r_lfsr);
        r_ramp  <= r_ramp + 8'sd1;
        if (r_sq_cnt == SQ_LAST) begin
          r_sq_cnt <= '0;
          r_sq_pos <= ~r_sq_pos;
        end else begin
          r_sq_cnt <= r_sq_cnt + SQ_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_source.sv
// Self-checking bench for sample_source: directed and randomized runs scored
// against an arithmetic model of strobe timing and waveform values.
module tb_sample_source;

  localparam int SQ = 2;

  logic              clk = 1'b0;
  logic              resetn;
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic signed [7:0] amp;
  logic [15:0]       fcw;
  logic [15:0]       burst_len;
  logic signed [7:0] x_n;
  logic              x_valid;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  logic [7:0] lfsr_tab [0:254];

  sample_source #(
    .ACC_W  (16),
    .SQ_HALF(SQ),
    .CNT_W  (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .amp      (amp),
    .fcw      (fcw),
    .burst_len(burst_len),
    .x_n      (x_n),
    .x_valid  (x_valid),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // k-th sample of a run (1-based), derived directly from the waveform definitions.
  function automatic logic signed [7:0] model_sample(input int m, input logic signed [7:0] a, input int k);
    int idx;
    int v;
    idx = k - 1;
    case (m)
      0: v = int'(a);
      1: begin
        if (((idx / SQ) % 2) == 0) v = int'(a);
        else if (int'(a) == -128) v = 127;
        else v = -int'(a);
      end
      2: v = (idx % 256) - 128;
      default: v = int'(lfsr_tab[idx % 255]);
    endcase
    return 8'(v);
  endfunction

  // One complete run: start, per-edge strobe/value/status scoring, then exit via
  // burst completion, abort after a given sample, or abort after max_edges.
  task automatic run_checked(input string tag, input int m, input logic signed [7:0] a,
                             input logic [15:0] f, input logic [15:0] bl, input int max_edges,
                             input int abort_after, input bit hold_start);
    longint c_prev;
    longint c_now;
    int k;
    bit exp_v;
    bit finished;
    bit bad;
    logic signed [7:0] exp_x;
    mode = 2'(m); amp = a; fcw = f; burst_len = bl; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    if (!hold_start) start = 1'b0;
    checks++;
    if (busy !== 1'b1 || x_valid !== 1'b0)
      begin errors++; $display("FAIL %s_start busy=%b x_valid=%b want busy=1 x_valid=0", tag, busy, x_valid); end
    c_prev = 0;
    finished = 1'b0;
    for (int n = 1; n <= max_edges && !finished; n++) begin
      @(posedge clk); #1;
      c_now = (longint'(n) * longint'(f)) / 65536;
      exp_v = (c_now != c_prev);
      k = int'(c_now);
      c_prev = c_now;
      checks++;
      if (x_valid !== exp_v)
        begin errors++; $display("FAIL %s_valid edge %0d got %b want %b", tag, n, x_valid, exp_v); end
      if (exp_v) begin
        exp_x = model_sample(m, a, k);
        checks++;
        if (x_n !== exp_x)
          begin errors++; $display("FAIL %s_x_n sample %0d got %0d want %0d", tag, k, x_n, exp_x); end
      end
      if (exp_v && bl != 0 && k == int'(bl)) begin
        finished = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b1)
          begin errors++; $display("FAIL %s_done busy=%b done=%b want busy=0 done=1", tag, busy, done); end
      end else if (exp_v && abort_after != 0 && k == abort_after) begin
        finished = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0)
          begin errors++; $display("FAIL %s_abort busy=%b done=%b x_valid=%b want 0 0 0", tag, busy, done, x_valid); end
        bad = 1'b0;
        for (int j = 0; j < 300; j++) begin
          @(posedge clk); #1;
          if (x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL %s_idle activity after abort got 1 want 0", tag); end
      end else begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL %s_busy edge %0d busy=%b done=%b want 1 0", tag, n, busy, done); end
      end
    end
    if (bl != 0 && abort_after == 0) begin
      checks++;
      if (!finished) begin
        errors++; $display("FAIL %s_timeout finished=0 want 1", tag);
        start = 1'b0; abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
      end else begin
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || x_valid !== 1'b0)
          begin errors++; $display("FAIL %s_after done=%b busy=%b x_valid=%b want 0 0 0", tag, done, busy, x_valid); end
        if (hold_start) begin
          @(posedge clk); #1;
          checks++;
          if (busy !== 1'b1) begin errors++; $display("FAIL %s_retrigger busy=%b want 1", tag, busy); end
          start = 1'b0; abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
        end
      end
    end else if (!finished) begin
      if (abort_after != 0) begin
        checks++; errors++;
        $display("FAIL %s_abort_timeout finished=0 want 1", tag);
      end
      start = 1'b0; abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0)
        begin errors++; $display("FAIL %s_stop busy=%b x_valid=%b done=%b want 0 0 0", tag, busy, x_valid, done); end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; amp = 8'sd0; fcw = 16'h0; burst_len = 16'h0;
    #12;
    checks++;
    if (x_n !== 8'sd0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL reset x_n=%0d x_valid=%b busy=%b done=%b want 0 0 0 0", x_n, x_valid, busy, done); end
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || x_valid !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset busy=%b x_valid=%b want 0 0", busy, x_valid); end
  endtask

  task automatic test_const_continuous();
    run_checked("const", 0, 8'sd4, 16'h0100, 16'd0, 800, 0, 1'b0);
  endtask

  task automatic test_square_burst();
    run_checked("square", 1, -8'sd128, 16'h8000, 16'd6, 20, 0, 1'b0);
    run_checked("square_pos", 1, 8'sd37, 16'h8000, 16'd6, 20, 0, 1'b0);
  endtask

  task automatic test_ramp_burst();
    run_checked("ramp", 2, 8'sd0, 16'hFFFF, 16'd258, 270, 0, 1'b0);
  endtask

  task automatic test_noise_restart();
    run_checked("noise1", 3, 8'sd0, 16'h4000, 16'd4, 20, 0, 1'b0);
    run_checked("noise2", 3, 8'sd0, 16'h4000, 16'd4, 20, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_checked("abort", 0, -8'sd9, 16'h2000, 16'd0, 100, 3, 1'b0);
  endtask

  task automatic test_fcw_zero();
    run_checked("fcw0", 0, 8'sd5, 16'h0000, 16'd0, 1000, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_checked("b2b", 2, 8'sd0, 16'h6000, 16'd5, 30, 0, 1'b1);
  endtask

  task automatic test_async_reset();
    mode = 2'd3; amp = 8'sd0; fcw = 16'h4000; burst_len = 16'd0; abort = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if (x_n !== 8'sd0 || x_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL async_reset x_n=%0d x_valid=%b busy=%b done=%b want 0 0 0 0", x_n, x_valid, busy, done); end
    #2;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_checked("noise_after_rst", 3, 8'sd0, 16'h4000, 16'd4, 20, 0, 1'b0);
  endtask

  task automatic test_random();
    int m;
    int bl;
    int ab;
    int f;
    int maxe;
    logic signed [7:0] a;
    for (int r = 0; r < 8; r++) begin
      m = int'($urandom_range(0, 3));
      a = 8'($urandom);
      f = int'($urandom_range(16'h0800, 16'hFFFF));
      bl = int'($urandom_range(1, 40));
      ab = 0;
      if (bl > 2 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, bl - 1));
      maxe = int'((longint'(bl) * 65536 + longint'(f) - 1) / longint'(f)) + 2;
      if (ab != 0) run_checked("rand_abort", m, a, 16'(f), 16'd0, maxe, ab, 1'b0);
      else run_checked("rand", m, a, 16'(f), 16'(bl), maxe, 0, 1'b0);
    end
  endtask

  initial begin
    lfsr_tab[0] = 8'h01;
    for (int i = 1; i < 255; i++) begin
      lfsr_tab[i] = {lfsr_tab[i-1][6:0],
                     lfsr_tab[i-1][7] ^ lfsr_tab[i-1][5] ^ lfsr_tab[i-1][4] ^ lfsr_tab[i-1][3]};
    end
    test_reset();
    test_const_continuous();
    test_square_burst();
    test_ramp_burst();
    test_noise_restart();
    test_abort();
    test_fcw_zero();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
